// File: rtl/moving_average_filter_param.sv
// rtl/moving_average_filter_param.sv - runtime-length boxcar moving average with saturated sum mode
//
// Purpose: boxcar average of the last L accepted samples, where L is len clamped to 1..MAX_LEN.
//   The running sum is normalised by multiplying with an unsigned reciprocal (RECIP_FRAC fraction
//   bits, floor). mode=1 outputs the saturated running sum instead. An accepted sample produces
//   its y/y_valid three clocks later; one sample per clock is sustained.
// Ports:
//   clk, reset_n         rising-edge clock, asynchronous active-low reset
//   en, x                sample qualifier and signed input sample
//   len                  requested window length (0 -> 1, above MAX_LEN -> MAX_LEN)
//   recip                reciprocal coefficient, sampled in the product stage
//   mode                 0 = average output, 1 = saturated raw running sum
//   flush                restart the window
//   y, y_valid, primed   held output sample, its one-cycle strobe, window-full flag

module moving_average_filter_param #(
  parameter int DATA_W     = 16,
  parameter int MAX_LEN    = 32,
  parameter int RECIP_W    = 18,
  parameter int RECIP_FRAC = 18
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      en,
  input  logic signed [DATA_W-1:0]  x,
  input  logic        [6:0]         len,
  input  logic        [RECIP_W-1:0] recip,
  input  logic                      mode,
  input  logic                      flush,
  output logic signed [DATA_W-1:0]  y,
  output logic                      y_valid,
  output logic                      primed
);

  localparam int SUM_W  = DATA_W + $clog2(MAX_LEN);
  localparam int PTR_W  = $clog2(MAX_LEN);
  localparam int CNT_W  = $clog2(MAX_LEN + 1);
  localparam int PROD_W = SUM_W + RECIP_W + 1;
  localparam logic [6:0] MAX_L = 7'(MAX_LEN);

  // Circular sample buffer; stale contents are masked by the fill count.
  logic signed [DATA_W-1:0] r_buf [MAX_LEN];

  logic        [6:0]        r_len_prev;
  logic                     r_s1_valid;
  logic signed [DATA_W-1:0] r_s1_x;
  logic signed [SUM_W-1:0]  r_sum;
  logic        [PTR_W-1:0]  r_wp;
  logic        [CNT_W-1:0]  r_fill;
  logic                     r_s2_valid;
  logic                     r_s2_primed;
  logic                     r_s3_valid;
  logic                     r_s3_primed;
  logic                     r_s3_mode;
  logic signed [SUM_W-1:0]  r_s3_sum;
  logic signed [PROD_W-1:0] r_s3_prod;

  logic        [6:0]        w_len_eff;
  logic                     w_restart;
  logic                     w_filling;
  logic signed [DATA_W-1:0] w_oldest;
  logic signed [DATA_W-1:0] w_sub;
  logic signed [SUM_W-1:0]  w_x_ext;
  logic signed [SUM_W-1:0]  w_sub_ext;
  logic signed [SUM_W-1:0]  w_sum_next;
  logic        [PTR_W-1:0]  w_wp_next;
  logic        [CNT_W-1:0]  w_fill_next;
  logic signed [PROD_W-1:0] w_sum_ext;
  logic signed [PROD_W-1:0] w_recip_ext;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] w_s3_sum_ext;
  logic signed [PROD_W-1:0] w_avg;
  logic signed [DATA_W-1:0] w_y_next;

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [PROD_W-1:0] v);
    logic signed [PROD_W-1:0] hi;
    logic signed [PROD_W-1:0] lo;
    hi = {{(PROD_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    lo = {{(PROD_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    if (v > hi)      sat = hi[DATA_W-1:0];
    else if (v < lo) sat = lo[DATA_W-1:0];
    else             sat = v[DATA_W-1:0];
  endfunction

  always_comb begin
    if (len == 7'd0)      w_len_eff = 7'd1;
    else if (len > MAX_L) w_len_eff = MAX_L;
    else                  w_len_eff = len;
  end

  // A change of effective length restarts the window just like flush.
  assign w_restart = flush || (w_len_eff != r_len_prev);

  // Until the window holds L samples nothing leaves it.
  assign w_filling   = (7'(r_fill) < w_len_eff);
  assign w_oldest    = r_buf[r_wp];
  assign w_sub       = w_filling ? '0 : w_oldest;
  assign w_x_ext     = {{(SUM_W-DATA_W){r_s1_x[DATA_W-1]}}, r_s1_x};
  assign w_sub_ext   = {{(SUM_W-DATA_W){w_sub[DATA_W-1]}}, w_sub};
  assign w_sum_next  = r_sum + w_x_ext - w_sub_ext;
  assign w_wp_next   = (7'(r_wp) == w_len_eff - 7'd1) ? '0 : r_wp + PTR_W'(1);
  assign w_fill_next = w_filling ? r_fill + CNT_W'(1) : r_fill;

  // Full-precision signed product; recip is zero-extended so it stays positive.
  assign w_sum_ext    = {{(PROD_W-SUM_W){r_sum[SUM_W-1]}}, r_sum};
  assign w_recip_ext  = {{(PROD_W-RECIP_W){1'b0}}, recip};
  assign w_prod       = w_sum_ext * w_recip_ext;
  assign w_s3_sum_ext = {{(PROD_W-SUM_W){r_s3_sum[SUM_W-1]}}, r_s3_sum};
  assign w_avg        = r_s3_prod >>> RECIP_FRAC;
  assign w_y_next     = sat(r_s3_mode ? w_s3_sum_ext : w_avg);

  always_ff @(posedge clk) begin
    if (r_s1_valid && !w_restart) begin
      r_buf[r_wp] <= r_s1_x;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_len_prev  <= 7'd1;
      r_s1_valid  <= 1'b0;
      r_s1_x      <= '0;
      r_sum       <= '0;
      r_wp        <= '0;
      r_fill      <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_primed <= 1'b0;
      r_s3_valid  <= 1'b0;
      r_s3_primed <= 1'b0;
      r_s3_mode   <= 1'b0;
      r_s3_sum    <= '0;
      r_s3_prod   <= '0;
      y           <= '0;
      y_valid     <= 1'b0;
      primed      <= 1'b0;
    end else begin
      r_len_prev <= w_len_eff;

      // Output stage: an already-computed result is delivered even on a restart cycle.
      y_valid <= r_s3_valid;
      if (r_s3_valid) begin
        y <= w_y_next;
        if (r_s3_primed) primed <= 1'b1;
      end

      // Product stage: mode and recip are captured here.
      r_s3_sum    <= r_sum;
      r_s3_prod   <= w_prod;
      r_s3_mode   <= mode;
      r_s3_primed <= r_s2_primed;

      if (w_restart) begin
        r_s1_valid <= 1'b0;
        r_s2_valid <= 1'b0;
        r_s3_valid <= 1'b0;
        r_sum      <= '0;
        r_wp       <= '0;
        r_fill     <= '0;
        primed     <= 1'b0;
      end else begin
        r_s1_valid <= en;
        if (en) r_s1_x <= x;
        r_s2_valid <= r_s1_valid;
        r_s3_valid <= r_s2_valid;
        if (r_s1_valid) begin
          r_sum       <= w_sum_next;
          r_wp        <= w_wp_next;
          r_fill      <= w_fill_next;
          r_s2_primed <= (7'(w_fill_next) == w_len_eff);
        end
      end
    end
  end

endmodule

// File: tb/tb_moving_average_filter_param.sv
// tb/tb_moving_average_filter_param.sv - scoreboard bench for moving_average_filter_param

module tb_moving_average_filter_param;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               en;
  logic signed [15:0] x;
  logic        [6:0]  len;
  logic        [17:0] recip;
  logic               mode;
  logic               flush;
  logic signed [15:0] y;
  logic               y_valid;
  logic               primed;

  moving_average_filter_param dut (
    .clk(clk), .reset_n(reset_n), .en(en), .x(x), .len(len), .recip(recip),
    .mode(mode), .flush(flush), .y(y), .y_valid(y_valid), .primed(primed)
  );

  always #5 clk = ~clk;

  typedef struct { int y; bit p; int due; } exp_t;

  exp_t sb[$];
  int   hist[$];
  int   prev_l;
  int   cyc;
  int   last_y;
  int   total;
  int   bad;

  function automatic int eff_len(int l);
    if (l == 0) return 1;
    if (l > 32) return 32;
    return l;
  endfunction

  function automatic int sat16(longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  task automatic model_push(input int xv, input int l);
    longint s;
    longint p;
    exp_t   ent;
    s = 0;
    hist.push_back(xv);
    if (hist.size() > l) void'(hist.pop_front());
    foreach (hist[i]) s += hist[i];
    p = s * longint'(recip);
    ent.y   = mode ? sat16(s) : sat16(p >>> 18);
    ent.p   = (hist.size() == l);
    ent.due = cyc + 3;
    sb.push_back(ent);
  endtask

  // Samples not yet at the output stage are lost; one leaving this cycle shows primed=0.
  task automatic model_restart();
    exp_t keep[$];
    exp_t ent;
    hist.delete();
    foreach (sb[i]) begin
      if (sb[i].due <= cyc) begin
        ent = sb[i];
        if (ent.due == cyc) ent.p = 1'b0;
        keep.push_back(ent);
      end
    end
    sb = keep;
  endtask

  task automatic cycle(input bit e, input int xv, input bit f);
    int l;
    cyc++;
    en    = e;
    x     = xv[15:0];
    flush = f;
    l = eff_len(int'(len));
    if (f || l != prev_l) model_restart();
    else if (e) model_push(xv, l);
    prev_l = l;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b0; x = '0; flush = 1'b0;
    len = 7'd25; recip = 18'd10486; mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (y !== 16'sd0 || y_valid !== 1'b0 || primed !== 1'b0) begin
      bad++;
      $display("FAIL reset_state y=%0d y_valid=%b primed=%b required 0/0/0", y, y_valid, primed);
    end
    sb.delete(); hist.delete(); prev_l = 1; last_y = 0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) cycle(1'b0, 0, 1'b0);
  endtask

  task automatic test_avg_ramp();
    exp_t e;
    int   n;
    n = 0;
    for (int i = 0; i < 46; i++) begin
      cycle(i < 40, 1000, 1'b0);
      if (y_valid) begin
        total++; n++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL ramp_out unexpected y_valid y=%0d", y);
        end else begin
          e = sb.pop_front(); last_y = e.y;
          if ($signed(y) !== e.y || primed !== e.p || cyc != e.due) begin
            bad++;
            $display("FAIL ramp_out y=%0d primed=%b cyc=%0d required y=%0d primed=%b cyc=%0d", y, primed, cyc, e.y, e.p, e.due);
          end
        end
        if (n == 1 || n == 25) begin
          total++;
          if ($signed(y) !== (n == 1 ? 40 : 1000) || primed !== (n == 25)) begin
            bad++; $display("FAIL ramp_point n=%0d y=%0d primed=%b", n, y, primed);
          end
        end
      end
    end
    total++;
    if (sb.size() != 0 || n != 40) begin
      bad++; $display("FAIL ramp_count outputs=%0d pending=%0d required 40/0", n, sb.size());
    end
  endtask

  task automatic test_floor();
    exp_t e;
    int   n;
    n = 0;
    for (int i = 0; i < 35; i++) begin
      cycle(i < 30, -2000, 1'b0);
      if (y_valid) begin
        total++; n++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL floor_out unexpected y_valid y=%0d", y);
        end else begin
          e = sb.pop_front(); last_y = e.y;
          if ($signed(y) !== e.y || primed !== e.p || cyc != e.due) begin
            bad++;
            $display("FAIL floor_out y=%0d primed=%b cyc=%0d required y=%0d primed=%b cyc=%0d", y, primed, cyc, e.y, e.p, e.due);
          end
        end
        if (n == 30) begin
          total++;
          if ($signed(y) !== -2001) begin
            bad++; $display("FAIL floor_steady y=%0d required -2001", y);
          end
        end
      end
    end
    total++;
    if (sb.size() != 0 || n != 30) begin
      bad++; $display("FAIL floor_count outputs=%0d pending=%0d required 30/0", n, sb.size());
    end
  endtask

  task automatic test_len4(input bit gaps);
    exp_t e;
    int   n;
    int   k;
    int   want [5];
    want = '{1, 3, 6, 10, 14};
    len = 7'd4; recip = 18'd65536; mode = 1'b0;
    cycle(1'b0, 0, 1'b1);
    cycle(1'b0, 0, 1'b0);
    n = 0; k = 0;
    for (int i = 0; i < 16; i++) begin
      if (k < 5 && (!gaps || i % 2 == 0)) begin
        cycle(1'b1, 4 * (k + 1), 1'b0);
        k++;
      end else begin
        cycle(1'b0, 99, 1'b0);
      end
      total++;
      if (y_valid) begin
        if (sb.size() == 0) begin
          bad++; $display("FAIL len4_out unexpected y_valid y=%0d", y);
        end else begin
          e = sb.pop_front(); last_y = e.y;
          if ($signed(y) !== e.y || primed !== e.p || cyc != e.due || n > 4 || e.y != want[n % 5]) begin
            bad++;
            $display("FAIL len4_out n=%0d y=%0d primed=%b cyc=%0d required y=%0d primed=%b cyc=%0d", n, y, primed, cyc, e.y, e.p, e.due);
          end
        end
        n++;
      end else if ($signed(y) !== last_y) begin
        bad++; $display("FAIL len4_hold y=%0d required %0d", y, last_y);
      end
    end
    total++;
    if (sb.size() != 0 || n != 5) begin
      bad++; $display("FAIL len4_count outputs=%0d pending=%0d required 5/0", n, sb.size());
    end
  endtask

  task automatic test_sum_sat();
    exp_t e;
    int   n;
    len = 7'd32; mode = 1'b1;
    cycle(1'b0, 0, 1'b0);
    n = 0;
    for (int i = 0; i < 68; i++) begin
      cycle(i < 64, (i < 32) ? 32767 : -32768, 1'b0);
      if (y_valid) begin
        total++; n++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL sat_out unexpected y_valid y=%0d", y);
        end else begin
          e = sb.pop_front(); last_y = e.y;
          if ($signed(y) !== e.y || primed !== e.p || cyc != e.due) begin
            bad++;
            $display("FAIL sat_out y=%0d primed=%b cyc=%0d required y=%0d primed=%b cyc=%0d", y, primed, cyc, e.y, e.p, e.due);
          end
        end
        if (n == 32 || n == 64) begin
          total++;
          if ($signed(y) !== (n == 32 ? 32767 : -32768)) begin
            bad++; $display("FAIL sat_limit n=%0d y=%0d", n, y);
          end
        end
      end
    end
    total++;
    if (sb.size() != 0 || n != 64) begin
      bad++; $display("FAIL sat_count outputs=%0d pending=%0d required 64/0", n, sb.size());
    end
  endtask

  task automatic test_restart();
    exp_t e;
    int   n;
    len = 7'd25; recip = 18'd10486; mode = 1'b0;
    n = 0;
    // 0-1 idle, 2-28 stream, 29 flush with en, 30-33 idle, 34 len change with en,
    // 35 idle, 36 x=800, 37-40 idle, 41-50 stream, then reset.
    for (int i = 0; i < 51; i++) begin
      if (i == 34) begin len = 7'd8; recip = 18'd32768; end
      if (i == 29)                                   cycle(1'b1, 500, 1'b1);
      else if (i >= 2 && i <= 28)                    cycle(1'b1, 500, 1'b0);
      else if (i == 34 || i == 36 || i >= 41)        cycle(1'b1, 800, 1'b0);
      else                                           cycle(1'b0, 0, 1'b0);
      if (y_valid) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL restart_out unexpected y_valid y=%0d cyc_idx=%0d", y, i);
        end else begin
          e = sb.pop_front(); last_y = e.y;
          if ($signed(y) !== e.y || primed !== e.p || cyc != e.due) begin
            bad++;
            $display("FAIL restart_out y=%0d primed=%b cyc=%0d required y=%0d primed=%b cyc=%0d", y, primed, cyc, e.y, e.p, e.due);
          end
        end
        if (i >= 36) begin
          n++;
          if (n == 1) begin
            total++;
            if ($signed(y) !== 100 || primed !== 1'b0) begin
              bad++; $display("FAIL restart_first y=%0d primed=%b required 100/0", y, primed);
            end
          end
        end
      end
      if (i == 29 || i == 34) begin
        total++;
        if (primed !== 1'b0) begin
          bad++; $display("FAIL restart_primed idx=%0d primed=%b required 0", i, primed);
        end
      end
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (y !== 16'sd0 || y_valid !== 1'b0 || primed !== 1'b0) begin
      bad++; $display("FAIL midreset y=%0d y_valid=%b primed=%b required 0/0/0", y, y_valid, primed);
    end
    sb.delete(); hist.delete(); prev_l = 1; last_y = 0;
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(i == 2, 800, 1'b0);
      if (y_valid) begin
        total++; n++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL postreset_out unexpected y_valid y=%0d", y);
        end else begin
          e = sb.pop_front(); last_y = e.y;
          if ($signed(y) !== e.y || $signed(y) !== 100 || primed !== e.p || cyc != e.due) begin
            bad++;
            $display("FAIL postreset_out y=%0d primed=%b cyc=%0d required y=%0d primed=%b cyc=%0d", y, primed, cyc, e.y, e.p, e.due);
          end
        end
      end
    end
    total++;
    if (sb.size() != 0 || n != 1) begin
      bad++; $display("FAIL postreset_count outputs=%0d pending=%0d required 1/0", n, sb.size());
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; prev_l = 1; last_y = 0;
    test_reset();
    test_avg_ramp();
    test_floor();
    test_len4(1'b0);
    test_len4(1'b1);
    test_sum_sat();
    test_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
